parking_occupancy_fsm: RTL and testbench
========================================

PARKING_OCCUPANCY_FSM -- requirements
Module: parking_occupancy_fsm

Interface
REQ-001 The block SHALL have these ports: clk input 1 (sole clock, rising edge); reset input 1 (synchronous, active-low); a input 1; b input 1; enter output 1; exit output 1.
REQ-002 a SHALL be the outer photo-sensor, 1 = blocked; b SHALL be the inner photo-sensor, 1 = blocked.
REQ-003 enter SHALL be a one-cycle pulse that marks one completed car entry; exit SHALL be a one-cycle pulse that marks one completed car exit.
REQ-004 The block SHALL have no parameters; all state SHALL be clocked by clk only.

Function
REQ-005 The FSM SHALL have states IDLE, EN1, EN2, EN3, EX1, EX2, EX3 and WAIT, encoded in 3 bits; {a,b} SHALL be sampled on every rising edge.
REQ-006 IDLE: 00 stays; 10 goes to EN1; 01 goes to EX1; 11 goes to WAIT.
REQ-007 EN1: 10 stays; 11 goes to EN2; 00 goes to IDLE with no pulse; 01 goes to WAIT.
REQ-008 EN2: 11 stays; 01 goes to EN3; 10 goes back to EN1; 00 goes to WAIT.
REQ-009 EN3: 01 stays; 11 goes back to EN2; 00 goes to IDLE and fires enter; 10 goes to WAIT.
REQ-010 EX1: 01 stays; 11 goes to EX2; 00 goes to IDLE with no pulse; 10 goes to WAIT.
REQ-011 EX2: 11 stays; 10 goes to EX3; 01 goes back to EX1; 00 goes to WAIT.
REQ-012 EX3: 10 stays; 11 goes back to EX2; 00 goes to IDLE and fires exit; 01 goes to WAIT.
REQ-013 WAIT: 00 goes to IDLE; any other value stays. No pulse SHALL be generated from WAIT.
REQ-014 enter and exit SHALL be registered; each SHALL be high for exactly one cycle, in the cycle after the edge that samples the completing 00.
REQ-015 enter and exit SHALL never be high in the same cycle; a held 00 SHALL NOT retrigger a pulse.
REQ-016 Partial reversals SHALL be tracked step by step, and any number of back-and-forth steps SHALL be allowed; only a full a→ab→b→none sequence (or its mirror) SHALL produce a pulse.
REQ-017 Transitions not listed in REQ-006 to REQ-012 SHALL NOT exist; the default branch SHALL go to WAIT.

Reset
REQ-018 When reset=0 is sampled at a rising edge, the state SHALL become IDLE and enter and exit SHALL be 0 in the next cycle.
REQ-019 Reset mid-sequence SHALL abort the sequence without a pulse; after reset=1, the FSM SHALL resume from IDLE using the current {a,b}.
REQ-020 Reset SHALL take priority over all other behaviour; without a clk edge, a and b SHALL have no effect.

Configuration
REQ-021 When macro PARKING_INPUT_SYNC_EN is defined, a and b SHALL each pass through a 2-flop synchronizer before the FSM, adding 2 cycles of latency to every transition and pulse; the synchronizer flops SHALL reset to 0.
REQ-022 When PARKING_INPUT_SYNC_EN is undefined, a and b SHALL feed the FSM directly, with the timing of REQ-014.

Verification
REQ-023 Entry: ab 00→10→11→01→00, each held 5 cycles → exactly one enter pulse, 1 cycle wide, 1 cycle after 00 is sampled; exit stays 0.
REQ-024 Exit: ab 00→01→11→10→00 → exactly one exit pulse; enter stays 0.
REQ-025 Half-entry and back-out: 10,11,01,11,10,00 → no pulses; FSM returns to IDLE.
REQ-026 Entry with reversal: 10,11,01,11,10,11,01,00 → exactly one enter. The mirrored exit sequence → exactly one exit.
REQ-027 Illegal jumps and noise: 00→11 (held)→00, and 10→00→01→00 → no pulses; WAIT is entered and then left on 00.
REQ-028 Reset: reset=0 while in EN3 with ab=01, then ab=00 with reset=1 → no enter pulse; state is IDLE.

Source files
------------

// File: rtl/parking_occupancy_fsm.sv
// ============================================================================
// Module   : parking_occupancy_fsm
// Purpose  : Two-sensor car entry/exit detector producing one-cycle pulses.
//            Optional macro PARKING_INPUT_SYNC_EN adds 2-flop input synchronizers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_occupancy_fsm (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic enter,
    output logic exit
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6,
        WAIT = 3'd7
    } state_t;

    state_t     r_state;
    logic       w_a;
    logic       w_b;
    logic [1:0] w_ab;

`ifdef PARKING_INPUT_SYNC_EN
    logic [1:0] r_a_sync;
    logic [1:0] r_b_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a_sync <= 2'b00;
            r_b_sync <= 2'b00;
        end else begin
            r_a_sync <= {r_a_sync[0], a};
            r_b_sync <= {r_b_sync[0], b};
        end
    end

    assign w_a = r_a_sync[1];
    assign w_b = r_b_sync[1];
`else
    assign w_a = a;
    assign w_b = b;
`endif

    assign w_ab = {w_a, w_b};

    // Pulses are registered and default low, so a held 00 in IDLE never retriggers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            enter   <= 1'b0;
            exit    <= 1'b0;
        end else begin
            enter <= 1'b0;
            exit  <= 1'b0;
            case (r_state)
                IDLE: case (w_ab)
                    2'b00: r_state <= IDLE;
                    2'b10: r_state <= EN1;
                    2'b01: r_state <= EX1;
                    2'b11: r_state <= WAIT;
                endcase
                EN1: case (w_ab)
                    2'b10: r_state <= EN1;
                    2'b11: r_state <= EN2;
                    2'b00: r_state <= IDLE;
                    2'b01: r_state <= WAIT;
                endcase
                EN2: case (w_ab)
                    2'b11: r_state <= EN2;
                    2'b01: r_state <= EN3;
                    2'b10: r_state <= EN1;
                    2'b00: r_state <= WAIT;
                endcase
                EN3: case (w_ab)
                    2'b01: r_state <= EN3;
                    2'b11: r_state <= EN2;
                    2'b00: begin
                        r_state <= IDLE;
                        enter   <= 1'b1;
                    end
                    2'b10: r_state <= WAIT;
                endcase
                EX1: case (w_ab)
                    2'b01: r_state <= EX1;
                    2'b11: r_state <= EX2;
                    2'b00: r_state <= IDLE;
                    2'b10: r_state <= WAIT;
                endcase
                EX2: case (w_ab)
                    2'b11: r_state <= EX2;
                    2'b10: r_state <= EX3;
                    2'b01: r_state <= EX1;
                    2'b00: r_state <= WAIT;
                endcase
                EX3: case (w_ab)
                    2'b10: r_state <= EX3;
                    2'b11: r_state <= EX2;
                    2'b00: begin
                        r_state <= IDLE;
                        exit    <= 1'b1;
                    end
                    2'b01: r_state <= WAIT;
                endcase
                WAIT: begin
                    if (w_ab == 2'b00) r_state <= IDLE;
                    else               r_state <= WAIT;
                end
                default: r_state <= WAIT;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_parking_occupancy_fsm.sv
// ============================================================================
// Module   : tb_parking_occupancy_fsm
// Purpose  : Scoreboard bench for parking_occupancy_fsm (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_occupancy_fsm;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic a     = 1'b0;
    logic b     = 1'b0;
    logic enter;
    logic exit;

    typedef struct {
        logic [1:0] exp;
        string      name;
    } item_t;

    item_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    parking_occupancy_fsm dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .enter (enter),
        .exit  (exit)
    );

    always #5 clk = ~clk;

    // Drive one input vector for n cycles; 'first' is the {enter,exit} expected
    // in the cycle after the first sampling edge, later cycles expect no pulse.
    task automatic hold(input string name, input logic rst, input logic [1:0] ab,
                        input int n, input logic [1:0] first);
        item_t it;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset  = rst;
            {a, b} = ab;
            it.exp  = (i == 0) ? first : 2'b00;
            it.name = name;
            exp_q.push_back(it);
        end
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                tests++;
                if ({enter, exit} !== it.exp) begin
                    fails++;
                    $display("FAIL %s @%0t: enter/exit=%b required %b",
                             it.name, $time, {enter, exit}, it.exp);
                end
            end
        end
    end

    initial begin : stimulus
        int budget;
        hold("reset", 1'b0, 2'b00, 3, 2'b00);
        hold("idle",  1'b1, 2'b00, 3, 2'b00);

        // Full entry, 5 cycles per step
        hold("entry", 1'b1, 2'b10, 5, 2'b00);
        hold("entry", 1'b1, 2'b11, 5, 2'b00);
        hold("entry", 1'b1, 2'b01, 5, 2'b00);
        hold("entry", 1'b1, 2'b00, 5, 2'b10);

        // Full exit
        hold("exit", 1'b1, 2'b01, 5, 2'b00);
        hold("exit", 1'b1, 2'b11, 5, 2'b00);
        hold("exit", 1'b1, 2'b10, 5, 2'b00);
        hold("exit", 1'b1, 2'b00, 5, 2'b01);

        // Half entry then back out
        hold("backout", 1'b1, 2'b10, 2, 2'b00);
        hold("backout", 1'b1, 2'b11, 2, 2'b00);
        hold("backout", 1'b1, 2'b01, 2, 2'b00);
        hold("backout", 1'b1, 2'b11, 2, 2'b00);
        hold("backout", 1'b1, 2'b10, 2, 2'b00);
        hold("backout", 1'b1, 2'b00, 3, 2'b00);

        // Entry with reversal
        hold("entry_rev", 1'b1, 2'b10, 2, 2'b00);
        hold("entry_rev", 1'b1, 2'b11, 2, 2'b00);
        hold("entry_rev", 1'b1, 2'b01, 2, 2'b00);
        hold("entry_rev", 1'b1, 2'b11, 2, 2'b00);
        hold("entry_rev", 1'b1, 2'b10, 2, 2'b00);
        hold("entry_rev", 1'b1, 2'b11, 2, 2'b00);
        hold("entry_rev", 1'b1, 2'b01, 2, 2'b00);
        hold("entry_rev", 1'b1, 2'b00, 3, 2'b10);

        // Exit with reversal (mirror)
        hold("exit_rev", 1'b1, 2'b01, 2, 2'b00);
        hold("exit_rev", 1'b1, 2'b11, 2, 2'b00);
        hold("exit_rev", 1'b1, 2'b10, 2, 2'b00);
        hold("exit_rev", 1'b1, 2'b11, 2, 2'b00);
        hold("exit_rev", 1'b1, 2'b01, 2, 2'b00);
        hold("exit_rev", 1'b1, 2'b11, 2, 2'b00);
        hold("exit_rev", 1'b1, 2'b10, 2, 2'b00);
        hold("exit_rev", 1'b1, 2'b00, 3, 2'b01);

        // Illegal jump to WAIT; WAIT must ignore an entry-like tail
        hold("wait_11", 1'b1, 2'b11, 4, 2'b00);
        hold("wait_11", 1'b1, 2'b10, 2, 2'b00);
        hold("wait_11", 1'b1, 2'b11, 2, 2'b00);
        hold("wait_11", 1'b1, 2'b01, 2, 2'b00);
        hold("wait_11", 1'b1, 2'b00, 3, 2'b00);

        // Noise: 10 -> 00 -> 01 -> 00
        hold("noise", 1'b1, 2'b10, 2, 2'b00);
        hold("noise", 1'b1, 2'b00, 2, 2'b00);
        hold("noise", 1'b1, 2'b01, 2, 2'b00);
        hold("noise", 1'b1, 2'b00, 2, 2'b00);

        // WAIT from EN1 (01), EN2 (00), EN3 (10), EX1 (10)
        hold("en1_wait", 1'b1, 2'b10, 2, 2'b00);
        hold("en1_wait", 1'b1, 2'b01, 2, 2'b00);
        hold("en1_wait", 1'b1, 2'b00, 2, 2'b00);
        hold("en2_wait", 1'b1, 2'b10, 1, 2'b00);
        hold("en2_wait", 1'b1, 2'b11, 1, 2'b00);
        hold("en2_wait", 1'b1, 2'b00, 1, 2'b00);
        hold("en2_wait", 1'b1, 2'b01, 2, 2'b00);
        hold("en2_wait", 1'b1, 2'b00, 2, 2'b00);
        hold("en3_wait", 1'b1, 2'b10, 1, 2'b00);
        hold("en3_wait", 1'b1, 2'b11, 1, 2'b00);
        hold("en3_wait", 1'b1, 2'b01, 1, 2'b00);
        hold("en3_wait", 1'b1, 2'b10, 2, 2'b00);
        hold("en3_wait", 1'b1, 2'b00, 2, 2'b00);
        hold("ex1_wait", 1'b1, 2'b01, 1, 2'b00);
        hold("ex1_wait", 1'b1, 2'b10, 1, 2'b00);
        hold("ex1_wait", 1'b1, 2'b11, 1, 2'b00);
        hold("ex1_wait", 1'b1, 2'b10, 1, 2'b00);
        hold("ex1_wait", 1'b1, 2'b00, 2, 2'b00);

        // Reset while in EN3 aborts the entry
        hold("rst_en3", 1'b1, 2'b10, 1, 2'b00);
        hold("rst_en3", 1'b1, 2'b11, 1, 2'b00);
        hold("rst_en3", 1'b1, 2'b01, 2, 2'b00);
        hold("rst_en3", 1'b0, 2'b01, 2, 2'b00);
        hold("rst_en3", 1'b1, 2'b00, 3, 2'b00);

        // Reset on the completing edge suppresses the pulse
        hold("rst_edge", 1'b1, 2'b10, 1, 2'b00);
        hold("rst_edge", 1'b1, 2'b11, 1, 2'b00);
        hold("rst_edge", 1'b1, 2'b01, 1, 2'b00);
        hold("rst_edge", 1'b0, 2'b00, 1, 2'b00);
        hold("rst_edge", 1'b1, 2'b00, 2, 2'b00);

        // Release reset with a=1 already blocked: resume from IDLE into EN1
        hold("rst_resume", 1'b0, 2'b10, 2, 2'b00);
        hold("rst_resume", 1'b1, 2'b10, 2, 2'b00);
        hold("rst_resume", 1'b1, 2'b11, 2, 2'b00);
        hold("rst_resume", 1'b1, 2'b01, 2, 2'b00);
        hold("rst_resume", 1'b1, 2'b00, 3, 2'b10);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
